// File: rtl/multicycle_control.sv
// Moore control FSM for a five-stage-style multicycle MIPS datapath.
// Datapath controls are registered alongside the state so they change only on Clk.
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_ADDI  = 6'h08
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [3:0] State
);

    localparam int unsigned ST_W  = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE    = 4'd0,
        FETCH   = 4'd1,
        DECODE  = 4'd2,
        MEMADDR = 4'd3,
        MEMRD   = 4'd4,
        MEMWB   = 4'd5,
        MEMWR   = 4'd6,
        EXEC    = 4'd7,
        ALUWB   = 4'd8,
        BRANCH  = 4'd9,
        JUMP    = 4'd10,
        ADDIEX  = 4'd11,
        ADDIWB  = 4'd12
    } state_t;

    typedef struct packed {
        logic             pcwrite;
        logic             branch;
        logic             iord;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic             irwrite;
        logic             alusrca;
        logic             regwrite;
        logic             regdst;
        logic [SEL_W-1:0] pcsource;
        logic [SEL_W-1:0] aluop;
        logic [SEL_W-1:0] alusrcb;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    // Next state; Op matters only when leaving DECODE or MEMADDR.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (Op == OP_LW || Op == OP_SW) state_d = MEMADDR;
                else if (Op == OP_RTYPE)        state_d = EXEC;
                else if (Op == OP_BEQ)          state_d = BRANCH;
                else if (Op == OP_J)            state_d = JUMP;
                else if (Op == OP_ADDI)         state_d = ADDIEX;
                else                            state_d = FETCH;
            end
            MEMADDR: state_d = (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXEC:    state_d = ALUWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // Controls for the state being entered, so the registered copy lines up with State.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH: begin
                ctrl_d.memread = 1'b1;
                ctrl_d.irwrite = 1'b1;
                ctrl_d.pcwrite = 1'b1;
                ctrl_d.alusrcb = 2'b01;
            end
            DECODE:  ctrl_d.alusrcb = 2'b11;
            MEMADDR, ADDIEX: begin
                ctrl_d.alusrca = 1'b1;
                ctrl_d.alusrcb = 2'b10;
            end
            MEMRD: begin
                ctrl_d.memread = 1'b1;
                ctrl_d.iord    = 1'b1;
            end
            MEMWR: begin
                ctrl_d.memwrite = 1'b1;
                ctrl_d.iord     = 1'b1;
            end
            MEMWB: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.memtoreg = 1'b1;
            end
            ADDIWB:  ctrl_d.regwrite = 1'b1;
            EXEC: begin
                ctrl_d.alusrca = 1'b1;
                ctrl_d.aluop   = 2'b10;
            end
            ALUWB: begin
                ctrl_d.regwrite = 1'b1;
                ctrl_d.regdst   = 1'b1;
            end
            BRANCH: begin
                ctrl_d.alusrca  = 1'b1;
                ctrl_d.aluop    = 2'b01;
                ctrl_d.branch   = 1'b1;
                ctrl_d.pcsource = 2'b01;
            end
            JUMP: begin
                ctrl_d.pcwrite  = 1'b1;
                ctrl_d.pcsource = 2'b10;
            end
            default: ctrl_d = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign PCWrite  = ctrl_q.pcwrite;
    assign Branch   = ctrl_q.branch;
    assign IorD     = ctrl_q.iord;
    assign MemRead  = ctrl_q.memread;
    assign MemWrite = ctrl_q.memwrite;
    assign MemtoReg = ctrl_q.memtoreg;
    assign IRWrite  = ctrl_q.irwrite;
    assign ALUSrcA  = ctrl_q.alusrca;
    assign RegWrite = ctrl_q.regwrite;
    assign RegDst   = ctrl_q.regdst;
    assign PCSource = ctrl_q.pcsource;
    assign ALUOp    = ctrl_q.aluop;
    assign ALUSrcB  = ctrl_q.alusrcb;
    assign State    = state_q;

endmodule
